// File: rtl/tcu_pattern_seq.sv
// rtl/tcu_pattern_seq.sv - per-frame delay/width sequencer feeding the TCU pair
// Optional feature macro: TCU_SEQ_LOOP_EN (wrap to entry 0 instead of stopping in DONE).
module tcu_pattern_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 6
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          trig,
    input  logic          run,
    input  logic [AW-1:0] len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_delay0,
    input  logic [DW-1:0] wr_width0,
    input  logic [DW-1:0] wr_delay1,
    input  logic [DW-1:0] wr_width1,
    output logic [DW-1:0] delay0,
    output logic [DW-1:0] width0,
    output logic [DW-1:0] delay1,
    output logic [DW-1:0] width1,
    output logic [AW-1:0] idx,
    output logic          active,
    output logic          done,
    output logic          sat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DW-1:0] MAXV = {DW{1'b1}};

    state_t          state;
    state_t          state_nxt;
    logic            trig_d;
    logic            fe;
    logic [AW-1:0]   len_q;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [4*DW-1:0] table_mem [DEPTH];

    logic [4*DW-1:0] rd_entry;
    logic [DW-1:0]   rd_delay0;
    logic [DW-1:0]   rd_width0;
    logic [DW-1:0]   rd_delay1;
    logic [DW-1:0]   rd_width1;
    logic [DW:0]     sum0;
    logic [DW:0]     sum1;
    logic            ovf0;
    logic            ovf1;
    logic [DW-1:0]   adj_width0;
    logic [DW-1:0]   adj_width1;

    assign fe = trig_d & ~trig;

    // No reset on the table: contents must survive a reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            table_mem[wr_addr] <= {wr_delay0, wr_width0, wr_delay1, wr_width1};
        end
    end

    // Same-cycle write/load reads the pre-write contents since the write lands at the edge.
    assign rd_entry = table_mem[load_addr];
    assign {rd_delay0, rd_width0, rd_delay1, rd_width1} = rd_entry;

    assign sum0       = {1'b0, rd_delay0} + {1'b0, rd_width0};
    assign sum1       = {1'b0, rd_delay1} + {1'b0, rd_width1};
    assign ovf0       = sum0[DW];
    assign ovf1       = sum1[DW];
    assign adj_width0 = ovf0 ? (MAXV - rd_delay0) : rd_width0;
    assign adj_width1 = ovf1 ? (MAXV - rd_delay1) : rd_width1;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (run) state_nxt = S_ARM;
            S_ARM: begin
                if (!run)    state_nxt = S_IDLE;
                else if (fe) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!run) begin
                    state_nxt = S_IDLE;
                end else if (fe && (idx == len_q)) begin
`ifdef TCU_SEQ_LOOP_EN
                    state_nxt = S_RUN;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: if (!run) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        active    = (state == S_ARM) || (state == S_RUN);
        done      = (state == S_DONE);
        load_en   = 1'b0;
        load_addr = '0;
        case (state)
            S_ARM: begin
                if (run && fe) load_en = 1'b1;
            end
            S_RUN: begin
                if (run && fe) begin
                    if (idx != len_q) begin
                        load_en   = 1'b1;
                        load_addr = idx + AW'(1);
                    end else begin
`ifdef TCU_SEQ_LOOP_EN
                        load_en   = 1'b1;
`else
                        load_en   = 1'b0;
`endif
                    end
                end
            end
            default: begin
                load_en   = 1'b0;
                load_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            trig_d <= 1'b0;
            len_q  <= '0;
            idx    <= '0;
            delay0 <= '0;
            width0 <= '0;
            delay1 <= '0;
            width1 <= '0;
            sat    <= 1'b0;
        end else begin
            trig_d <= trig;
            if ((state == S_IDLE) && run) begin
                len_q <= len;
                sat   <= 1'b0;
            end
            if (load_en) begin
                idx    <= load_addr;
                delay0 <= rd_delay0;
                width0 <= adj_width0;
                delay1 <= rd_delay1;
                width1 <= adj_width1;
                if (ovf0 || ovf1) sat <= 1'b1;
            end
        end
    end

endmodule
